// File: rtl/al_accel_pkg.sv
// Shared constants and beat type for the al_accel requantization datapath.
package al_accel_pkg;

    localparam int DEF_ACC_W = 32;
    localparam int DEF_OUT_W = 8;

    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

    // Rounding nudges applied to the 64-bit product before the Q31 divide.
    localparam logic signed [63:0] Q31_NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] Q31_NUDGE_NEG = -64'sd1073741823;

    typedef struct packed {
        logic signed [DEF_OUT_W-1:0] lane2;
        logic signed [DEF_OUT_W-1:0] lane1;
        logic signed [DEF_OUT_W-1:0] lane0;
    } rq_beat_t;

endpackage

// File: rtl/al_accel_requant_lane.sv
// One requant lane: S1 bias add, S2 product, S3 rounding doubling high multiply,
// S4 rounding shift + offset + clamp. Bias add only with AL_ACCEL_REQUANT_BIAS_EN.
module al_accel_requant_lane
    import al_accel_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic signed [ACC_W-1:0] acc,
`ifdef AL_ACCEL_REQUANT_BIAS_EN
    input  logic signed [ACC_W-1:0] bias,
`endif
    input  logic signed [ACC_W-1:0] mult,
    input  logic        [4:0]       shift,
    input  logic signed [ACC_W-1:0] offset,
    input  logic signed [OUT_W-1:0] act_min,
    input  logic signed [OUT_W-1:0] act_max,
    output logic signed [OUT_W-1:0] res
);

    localparam int P_W = 2 * ACC_W;

    logic signed [ACC_W-1:0] x_q;
    logic signed [P_W-1:0]   p_q;
    logic                    sat_q;
    logic signed [ACC_W-1:0] h_q;

    logic signed [P_W-1:0]   t;
    logic signed [P_W-1:0]   tq;
    logic signed [ACC_W-1:0] h_d;
    logic        [ACC_W-1:0] mask;
    logic        [ACC_W-1:0] rem;
    logic        [ACC_W-1:0] thr;
    logic signed [ACC_W-1:0] sh;
    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] y;
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] hi;
    logic signed [OUT_W-1:0] res_d;

    // S3: arithmetic shift floors; bump negatives with a nonzero fraction to truncate toward zero.
    always_comb begin
        t   = p_q + (p_q[P_W-1] ? Q31_NUDGE_NEG : Q31_NUDGE_POS);
        tq  = t >>> 31;
        h_d = sat_q ? INT32_MAX
                    : ACC_W'(tq) + ACC_W'(t[P_W-1] && (|t[30:0]));
    end

    always_comb begin
        mask  = (ACC_W'(1) << shift) - ACC_W'(1);
        rem   = h_q & mask;
        thr   = (mask >> 1) + ACC_W'(h_q[ACC_W-1]);
        sh    = h_q >>> shift;
        r     = sh + ACC_W'(rem > thr);
        y     = r + offset;
        lo    = {{(ACC_W-OUT_W){act_min[OUT_W-1]}}, act_min};
        hi    = {{(ACC_W-OUT_W){act_max[OUT_W-1]}}, act_max};
        res_d = OUT_W'(y);
        if (y < lo) begin
            res_d = act_min;
        end else if (y > hi) begin
            res_d = act_max;
        end
    end

    // Datapath registers carry no reset; the top-level valid bits qualify them.
    always_ff @(posedge clk) begin
`ifdef AL_ACCEL_REQUANT_BIAS_EN
        x_q   <= acc + bias;
`else
        x_q   <= acc;
`endif
        p_q   <= P_W'(x_q) * P_W'(mult);
        sat_q <= (x_q == INT32_MIN) && (mult == INT32_MIN);
        h_q   <= h_d;
        res   <= res_d;
    end

endmodule

// File: rtl/al_accel_requant.sv
// Three-lane int8 requantization stage with output FIFO and credit signal.
// Optional per-lane bias ports and S1 bias add under AL_ACCEL_REQUANT_BIAS_EN.
module al_accel_requant
    import al_accel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             rq_in_vld,
    input  logic [ACC_W-1:0] rq_in_dat_0,
    input  logic [ACC_W-1:0] rq_in_dat_1,
    input  logic [ACC_W-1:0] rq_in_dat_2,
    output logic             rq_in_rdy,
`ifdef AL_ACCEL_REQUANT_BIAS_EN
    input  logic [ACC_W-1:0] rq_bias_0,
    input  logic [ACC_W-1:0] rq_bias_1,
    input  logic [ACC_W-1:0] rq_bias_2,
`endif
    input  logic [ACC_W-1:0] rq_out_multiplier,
    input  logic [4:0]       rq_out_shift,
    input  logic [ACC_W-1:0] rq_output_offset,
    input  logic [OUT_W-1:0] rq_act_min,
    input  logic [OUT_W-1:0] rq_act_max,
    output logic             rq_out_vld,
    input  logic             rq_out_rdy,
    output logic [OUT_W-1:0] rq_out_dat_0,
    output logic [OUT_W-1:0] rq_out_dat_1,
    output logic [OUT_W-1:0] rq_out_dat_2,
    output logic             rq_ovf,
    input  logic             rq_ovf_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TOT_W = CNT_W + 1;

    logic [3:0]              stg_vld;
    logic signed [ACC_W-1:0] acc_a  [3];
    logic signed [ACC_W-1:0] bias_a [3];
    logic signed [OUT_W-1:0] res_a  [3];

    rq_beat_t                beat_in;
    rq_beat_t                head;
    rq_beat_t                mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [TOT_W-1:0]        total;
    logic                    rdy_q;

    assign acc_a[0] = rq_in_dat_0;
    assign acc_a[1] = rq_in_dat_1;
    assign acc_a[2] = rq_in_dat_2;
`ifdef AL_ACCEL_REQUANT_BIAS_EN
    assign bias_a[0] = rq_bias_0;
    assign bias_a[1] = rq_bias_1;
    assign bias_a[2] = rq_bias_2;
`else
    assign bias_a[0] = '0;
    assign bias_a[1] = '0;
    assign bias_a[2] = '0;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_lane
        al_accel_requant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
            .clk     (clk),
            .acc     (acc_a[i]),
`ifdef AL_ACCEL_REQUANT_BIAS_EN
            .bias    (bias_a[i]),
`endif
            .mult    (rq_out_multiplier),
            .shift   (rq_out_shift),
            .offset  (rq_output_offset),
            .act_min (rq_act_min),
            .act_max (rq_act_max),
            .res     (res_a[i])
        );
    end

    assign beat_in.lane0 = res_a[0];
    assign beat_in.lane1 = res_a[1];
    assign beat_in.lane2 = res_a[2];

    // Input side has no backpressure: a beat is captured whenever enb && rq_in_vld,
    // and rq_in_rdy is only an advisory credit. Output side is strict valid/ready:
    // a beat transfers on the edge where rq_out_vld && rq_out_rdy, and head data is
    // held stable while rq_out_vld is high and rq_out_rdy is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_vld <= '0;
        end else begin
            stg_vld <= {stg_vld[2:0], enb & rq_in_vld};
        end
    end

    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = rq_out_vld && rq_out_rdy;
    assign push = stg_vld[3] && (!full || pop);
    assign drop = stg_vld[3] && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= beat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head         = mem[rd_ptr];
    assign rq_out_vld   = (count != '0);
    assign rq_out_dat_0 = rq_out_vld ? head.lane0 : '0;
    assign rq_out_dat_1 = rq_out_vld ? head.lane1 : '0;
    assign rq_out_dat_2 = rq_out_vld ? head.lane2 : '0;

    // Credit covers every beat already committed: all four stages plus FIFO contents.
    assign total = TOT_W'(count) + TOT_W'(stg_vld[0]) + TOT_W'(stg_vld[1])
                 + TOT_W'(stg_vld[2]) + TOT_W'(stg_vld[3]);

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q  <= 1'b1;
            rq_ovf <= 1'b0;
        end else begin
            rdy_q <= (total < TOT_W'(FIFO_DEPTH));
            if (drop) begin
                rq_ovf <= 1'b1;
            end else if (rq_ovf_clr) begin
                rq_ovf <= 1'b0;
            end
        end
    end

    assign rq_in_rdy = rdy_q;

endmodule

// File: tb/tb_al_accel_requant.sv
// Self-checking bench for al_accel_requant: directed cases, random beats, backpressure, reset.
module tb_al_accel_requant;

    logic               clk = 1'b0;
    logic               reset;
    logic               enb;
    logic               in_vld;
    logic [31:0]        dat0, dat1, dat2;
    logic               in_rdy;
    logic signed [31:0] bias [3];
    logic signed [31:0] mult;
    logic [4:0]         shift;
    logic signed [31:0] offset;
    logic signed [7:0]  act_min, act_max;
    logic               out_vld;
    logic               out_rdy;
    logic [7:0]         out0, out1, out2;
    logic               ovf;
    logic               ovf_clr;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [23:0]        exp_q[$];

    always #5 clk = ~clk;

    al_accel_requant #(.FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .enb               (enb),
        .rq_in_vld         (in_vld),
        .rq_in_dat_0       (dat0),
        .rq_in_dat_1       (dat1),
        .rq_in_dat_2       (dat2),
        .rq_in_rdy         (in_rdy),
`ifdef AL_ACCEL_REQUANT_BIAS_EN
        .rq_bias_0         (bias[0]),
        .rq_bias_1         (bias[1]),
        .rq_bias_2         (bias[2]),
`endif
        .rq_out_multiplier (mult),
        .rq_out_shift      (shift),
        .rq_output_offset  (offset),
        .rq_act_min        (act_min),
        .rq_act_max        (act_max),
        .rq_out_vld        (out_vld),
        .rq_out_rdy        (out_rdy),
        .rq_out_dat_0      (out0),
        .rq_out_dat_1      (out1),
        .rq_out_dat_2      (out2),
        .rq_ovf            (ovf),
        .rq_ovf_clr        (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference requant written from the arithmetic definition using integer division.
    function automatic logic [7:0] rq_model(int acc, int b, int m, int s, int off, int mn, int mx);
        int     x;
        longint p, h, q, rm, dv, arm;
        int     y;
        x = acc + b;
        p = longint'(x) * longint'(m);
        if (x == 32'sh8000_0000 && m == 32'sh8000_0000) begin
            h = 64'sd2147483647;
        end else begin
            h = (p + ((p >= 0) ? 64'sd1073741824 : -64'sd1073741823)) / 64'sd2147483648;
        end
        dv  = 64'sd1 << s;
        q   = h / dv;
        rm  = h - q * dv;
        arm = (rm < 0) ? -rm : rm;
        if (2 * arm >= dv && s != 0) begin
            q = (h < 0) ? q - 1 : q + 1;
        end
        y = int'(q) + off;
        if (y < mn) y = mn;
        if (y > mx) y = mx;
        return 8'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int a0, input int a1, input int a2);
        in_vld = 1'b1;
        dat0   = a0;
        dat1   = a1;
        dat2   = a2;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic send(input int a0, input int a1, input int a2, input bit keep);
        if (keep) begin
            exp_q.push_back({rq_model(a2, bias[2], mult, int'(shift), offset, act_min, act_max),
                             rq_model(a1, bias[1], mult, int'(shift), offset, act_min, act_max),
                             rq_model(a0, bias[0], mult, int'(shift), offset, act_min, act_max)});
        end
        drive_beat(a0, a1, a2);
    endtask

    task automatic send_exp(input int a0, input int a1, input int a2,
                            input int e0, input int e1, input int e2);
        exp_q.push_back({8'(e2), 8'(e1), 8'(e0)});
        drive_beat(a0, a1, a2);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            tick();
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic set_cfg(input int m, input int s, input int off, input int mn, input int mx);
        mult    = m;
        shift   = 5'(s);
        offset  = off;
        act_min = 8'(mn);
        act_max = 8'(mx);
    endtask

    // Scoreboard: every transferred output beat is compared with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_vld), 0);
                end else begin
                    check("beat", {8'h0, out2, out1, out0}, {8'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached with %0d beats pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        enb     = 1'b0;
        in_vld  = 1'b0;
        dat0    = '0;
        dat1    = '0;
        dat2    = '0;
        out_rdy = 1'b1;
        ovf_clr = 1'b0;
        for (int i = 0; i < 3; i++) bias[i] = 0;
        set_cfg(32'h4000_0000, 0, 0, -128, 127);
        repeat (3) tick();
        reset = 1'b0;

        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_out_dat", {8'h0, out2, out1, out0}, 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_in_rdy", 32'(in_rdy), 1);

        // Basic scaling and 4-cycle latency
        enb = 1'b1;
        send_exp(100, 3, -4, 50, 2, -2);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("lat_vld", 32'(out_vld), (i == 4) ? 1 : 0);
        end
        check("basic_lane0", 32'(out0), 32'd50);
        check("basic_lane2", 32'(out2), 32'hFE);
        send(-3, 7, 0, 1);
        wait_drain();

        // Rounding shift, half away from zero
        set_cfg(32'h7FFF_FFFF, 1, 0, -128, 127);
        send_exp(5, -5, 4, 3, -3, 2);
        wait_drain();

        // Offset and clamp
        set_cfg(32'h7FFF_FFFF, 0, -128, -128, 127);
        send_exp(1000, -1000, 0, 127, -128, -128);
        wait_drain();
        set_cfg(32'h7FFF_FFFF, 0, -128, 0, 100);
        send_exp(50, 150, 250, 0, 22, 100);
        wait_drain();

        // Saturation corner and shift by 31
        set_cfg(32'h8000_0000, 31, 0, -128, 127);
        send_exp(32'h8000_0000, -1073741824, 32'h7FFF_FFFF, 1, 1, -1);
        wait_drain();

        // Random configurations, back-to-back beats
        for (int r = 0; r < 3; r++) begin
            int a, b;
            a = int'($urandom_range(255)) - 128;
            b = int'($urandom_range(255)) - 128;
            set_cfg(int'($urandom()), int'($urandom_range(31)), int'($urandom_range(200)) - 100,
                    (a < b) ? a : b, (a < b) ? b : a);
`ifdef AL_ACCEL_REQUANT_BIAS_EN
            for (int i = 0; i < 3; i++) bias[i] = int'($urandom());
`endif
            for (int k = 0; k < 8; k++) begin
                send(int'($urandom()), int'($urandom()), int'($urandom()), 1);
            end
            wait_drain();
        end
        for (int i = 0; i < 3; i++) bias[i] = 0;

        // Backpressure: 6 beats into a 4-deep FIFO, last 2 dropped
        set_cfg(32'h7FFF_FFFF, 0, 0, -128, 127);
        out_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) send_exp(k, k + 10, k + 20, k, k + 10, k + 20);
            else       send(k, k + 10, k + 20, 0);
            if (k == 3) check("bp_rdy_after4", 32'(in_rdy), 1);
            if (k == 4) check("bp_rdy_after5", 32'(in_rdy), 0);
        end
        repeat (5) tick();
        check("bp_in_rdy", 32'(in_rdy), 0);
        check("bp_out_vld", 32'(out_vld), 1);
        check("bp_ovf", 32'(ovf), 1);
        out_rdy = 1'b1;
        wait_drain();
        check("ovf_sticky", 32'(ovf), 1);
        check("drain_in_rdy", 32'(in_rdy), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 0);

        // Reset with 1 beat buffered and 2 in flight
        out_rdy = 1'b0;
        send(1, 2, 3, 0);
        repeat (2) tick();
        send(4, 5, 6, 0);
        send(7, 8, 9, 0);
        check("pre_rst_vld", 32'(out_vld), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_vld", 32'(out_vld), 0);
        check("mid_rst_rdy", 32'(in_rdy), 1);
        out_rdy = 1'b1;
        // Disabled stage ignores valid accumulators
        enb    = 1'b0;
        in_vld = 1'b1;
        repeat (3) tick();
        in_vld = 1'b0;
        enb    = 1'b1;
        repeat (10) tick();
        check("post_rst_vld", 32'(out_vld), 0);

`ifdef AL_ACCEL_REQUANT_BIAS_EN
        set_cfg(32'h7FFF_FFFF, 0, 0, -128, 127);
        bias[0] = 10;
        bias[1] = 20;
        bias[2] = -30;
        send_exp(0, 0, 0, 10, 20, -30);
        wait_drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
